// File: rtl/instr_encoder.sv
// Sequential MIPS instruction assembler: packs one field per load pulse and hands the word
// to the instruction-memory writer with valid/ready. Optional mnemonic display: ENC_SEG_EN.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op_sel,
  input  logic [15:0]       field_in,
  input  logic              field_load,
  input  logic              abort,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              busy,
  output logic [6:0]        seg_first,
  output logic [6:0]        seg_second,
  output logic [6:0]        seg_third,
  output logic [6:0]        seg_fourth,
  output logic [6:0]        seg_fifth
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 3;
  localparam logic [OP_W-1:0] OP_R = 3'd0;
  localparam logic [OP_W-1:0] OP_J = 3'd7;

  typedef enum logic [3:0] {
    IDLE, RS, RT, RD, FUNCT, IMM, TGT_HI, TGT_LO, EMIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
  logic [OP_W-1:0]     r_op, w_op_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_valid;

  function automatic logic [5:0] f_opcode(input logic [OP_W-1:0] op);
    case (op)
      3'd0:    f_opcode = 6'b000000;
      3'd1:    f_opcode = 6'b001000;
      3'd2:    f_opcode = 6'b001100;
      3'd3:    f_opcode = 6'b100011;
      3'd4:    f_opcode = 6'b101011;
      3'd5:    f_opcode = 6'b000100;
      3'd6:    f_opcode = 6'b000101;
      default: f_opcode = 6'b000010;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath next values; abort beats field_load in the field stages
  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    case (r_state)
      IDLE: begin
        if (field_load) begin
          w_op_nxt    = op_sel;
          w_instr_nxt = {f_opcode(op_sel), 26'b0};
          w_state_nxt = (op_sel == OP_J) ? TGT_HI : RS;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (field_load) begin
          case (r_state)
            RS: begin
              w_instr_nxt[25:21] = field_in[4:0];
              w_state_nxt        = RT;
            end
            RT: begin
              w_instr_nxt[20:16] = field_in[4:0];
              w_state_nxt        = (r_op == OP_R) ? RD : IMM;
            end
            RD: begin
              w_instr_nxt[15:11] = field_in[4:0];
              w_state_nxt        = FUNCT;
            end
            FUNCT: begin
              w_instr_nxt[10:0] = {5'b0, field_in[5:0]};
              w_state_nxt       = EMIT;
            end
            IMM: begin
              w_instr_nxt[15:0] = field_in;
              w_state_nxt       = EMIT;
            end
            TGT_HI: begin
              w_instr_nxt[25:16] = field_in[9:0];
              w_state_nxt        = TGT_LO;
            end
            TGT_LO: begin
              w_instr_nxt[15:0] = field_in;
              w_state_nxt       = EMIT;
            end
            default: w_state_nxt = IDLE;
          endcase
        end
      end
    endcase
  end

  // Datapath registers; valid tracks entry into and exit from EMIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_instr <= w_instr_nxt;
      r_op    <= w_op_nxt;
      r_addr  <= w_addr_nxt;
      r_valid <= (w_state_nxt == EMIT);
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign instr_addr  = r_addr;
  assign busy        = (r_state != IDLE);

`ifdef ENC_SEG_EN
  localparam logic [6:0] SEG_BL = 7'h7F;
  localparam logic [6:0] SEG_A  = 7'h08;
  localparam logic [6:0] SEG_D  = 7'h21;
  localparam logic [6:0] SEG_I  = 7'h7B;
  localparam logic [6:0] SEG_N  = 7'h2B;
  localparam logic [6:0] SEG_L  = 7'h47;
  localparam logic [6:0] SEG_W  = 7'h63;
  localparam logic [6:0] SEG_S  = 7'h12;
  localparam logic [6:0] SEG_B  = 7'h03;
  localparam logic [6:0] SEG_E  = 7'h06;
  localparam logic [6:0] SEG_Q  = 7'h18;
  localparam logic [6:0] SEG_J  = 7'h61;
  localparam logic [6:0] SEG_R  = 7'h2F;

  logic [34:0] r_seg;

  // Active-low {g,f,e,d,c,b,a} glyphs, leftmost digit in the top bits
  function automatic logic [34:0] f_mnemonic(input logic [OP_W-1:0] op);
    case (op)
      3'd0:    f_mnemonic = {SEG_R, SEG_BL, SEG_BL, SEG_BL, SEG_BL};
      3'd1:    f_mnemonic = {SEG_A, SEG_D,  SEG_D,  SEG_I,  SEG_BL};
      3'd2:    f_mnemonic = {SEG_A, SEG_N,  SEG_D,  SEG_I,  SEG_BL};
      3'd3:    f_mnemonic = {SEG_L, SEG_W,  SEG_BL, SEG_BL, SEG_BL};
      3'd4:    f_mnemonic = {SEG_S, SEG_W,  SEG_BL, SEG_BL, SEG_BL};
      3'd5:    f_mnemonic = {SEG_B, SEG_E,  SEG_Q,  SEG_BL, SEG_BL};
      3'd6:    f_mnemonic = {SEG_B, SEG_N,  SEG_E,  SEG_BL, SEG_BL};
      default: f_mnemonic = {SEG_J, SEG_BL, SEG_BL, SEG_BL, SEG_BL};
    endcase
  endfunction

  // Display holds the last accepted opcode until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           r_seg <= {5{SEG_BL}};
    else if (r_state == IDLE && field_load) r_seg <= f_mnemonic(op_sel);
  end

  assign seg_first  = r_seg[34:28];
  assign seg_second = r_seg[27:21];
  assign seg_third  = r_seg[20:14];
  assign seg_fourth = r_seg[13:7];
  assign seg_fifth  = r_seg[6:0];
`else
  assign seg_first  = 7'h7F;
  assign seg_second = 7'h7F;
  assign seg_third  = 7'h7F;
  assign seg_fourth = 7'h7F;
  assign seg_fifth  = 7'h7F;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, handshake, abort/reset and address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op_sel;
  logic [15:0] field_in;
  logic        field_load;
  logic        abort;
  logic        out_ready;

  logic [31:0] instr, instr2;
  logic        instr_valid, instr_valid2;
  logic [7:0]  instr_addr;
  logic [1:0]  instr_addr2;
  logic        busy, busy2;
  logic [6:0]  s1, s2, s3, s4, s5;
  logic [6:0]  t1, t2, t3, t4, t5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) u_dut (
    .clk(clk), .reset(reset), .op_sel(op_sel), .field_in(field_in),
    .field_load(field_load), .abort(abort), .out_ready(out_ready),
    .instr(instr), .instr_valid(instr_valid), .instr_addr(instr_addr), .busy(busy),
    .seg_first(s1), .seg_second(s2), .seg_third(s3), .seg_fourth(s4), .seg_fifth(s5)
  );

  // Narrow-address copy sharing the same stimulus, used for the wrap check
  instr_encoder #(.ADDR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .op_sel(op_sel), .field_in(field_in),
    .field_load(field_load), .abort(abort), .out_ready(out_ready),
    .instr(instr2), .instr_valid(instr_valid2), .instr_addr(instr_addr2), .busy(busy2),
    .seg_first(t1), .seg_second(t2), .seg_third(t3), .seg_fourth(t4), .seg_fifth(t5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] op, input logic [15:0] f);
    op_sel     = op;
    field_in   = f;
    field_load = 1'b1;
    step();
    field_load = 1'b0;
    field_in   = 16'hDEAD;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; op_sel = '0; field_in = '0; field_load = 1'b0; abort = 1'b0; out_ready = 1'b0;
    do_reset();
    chk("rst_instr", 64'(instr), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_addr", 64'(instr_addr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_seg", 64'({s1, s2, s3, s4, s5}), 64'({5{7'h7F}}));

    // addi $8,$0,5
    load(3'd1, 16'h0000);
    chk("addi_busy", 64'(busy), 64'h1);
    load(3'd0, 16'h0000);
    load(3'd0, 16'h0008);
    chk("addi_not_valid", 64'(instr_valid), 64'h0);
    load(3'd0, 16'h0005);
    chk("addi_valid", 64'(instr_valid), 64'h1);
    chk("addi_instr", 64'(instr), 64'h20080005);
    chk("addi_addr", 64'(instr_addr), 64'h0);
`ifdef ENC_SEG_EN
    chk("addi_seg", 64'({s1, s2, s3, s4, s5}), 64'({7'h08, 7'h21, 7'h21, 7'h7B, 7'h7F}));
`else
    chk("addi_seg", 64'({s1, s2, s3, s4, s5}), 64'({5{7'h7F}}));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("addi_addr_inc", 64'(instr_addr), 64'h1);
    chk("addi_valid_drop", 64'(instr_valid), 64'h0);
    chk("addi_idle", 64'(busy), 64'h0);

    // add $3,$1,$2 with junk in unused field bits, then 3 cycles of backpressure
    load(3'd0, 16'hFFFF);
    load(3'd5, 16'hFFE1);
    load(3'd5, 16'hFFE2);
    load(3'd5, 16'hFFE3);
    load(3'd5, 16'hFFE0);
    chk("r_instr", 64'(instr), 64'h00221820);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", 64'(instr_valid), 64'h1);
      chk("bp_instr", 64'(instr), 64'h00221820);
      chk("bp_addr", 64'(instr_addr), 64'h1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_addr_inc", 64'(instr_addr), 64'h2);
    chk("bp_valid_drop", 64'(instr_valid), 64'h0);

    // j 0x40: exactly three loads; loads and aborts in EMIT are ignored
    load(3'd7, 16'h0000);
    load(3'd0, 16'h0000);
    chk("j_not_valid", 64'(instr_valid), 64'h0);
    load(3'd0, 16'h0040);
    chk("j_valid", 64'(instr_valid), 64'h1);
    chk("j_instr", 64'(instr), 64'h08000040);
    load(3'd1, 16'h1234);
    chk("emit_load_ign", 64'(instr), 64'h08000040);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("emit_abort_ign", 64'(instr_valid), 64'h1);
`ifdef ENC_SEG_EN
    chk("j_seg", 64'({s1, s2, s3, s4, s5}), 64'({7'h61, {4{7'h7F}}}));
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("j_addr_inc", 64'(instr_addr), 64'h3);

    // abort together with a load in RT
    load(3'd1, 16'h0000);
    load(3'd0, 16'h0005);
    abort = 1'b1;
    op_sel = 3'd0; field_in = 16'h0006; field_load = 1'b1;
    step();
    abort = 1'b0; field_load = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    chk("abort_valid", 64'(instr_valid), 64'h0);
    chk("abort_addr", 64'(instr_addr), 64'h3);

    // reset asserted while waiting for the immediate
    load(3'd2, 16'h0000);
    load(3'd0, 16'h0001);
    load(3'd0, 16'h0002);
    chk("pre_rst_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_addr", 64'(instr_addr), 64'h0);
    chk("async_rst_seg", 64'({s1, s2, s3, s4, s5}), 64'({5{7'h7F}}));
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_valid", 64'(instr_valid), 64'h0);
      chk("post_rst_instr", 64'(instr), 64'h0);
    end

    // five zero-wait emits on the 2-bit address instance
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      load(3'd7, 16'h0000);
      load(3'd0, 16'h0000);
      load(3'd0, 16'(k));
      chk("wrap_valid", 64'(instr_valid2), 64'h1);
      chk("wrap_addr", 64'(instr_addr2), 64'(k % 4));
      step();
      chk("wrap_one_cycle", 64'(instr_valid2), 64'h0);
    end
    chk("wide_addr", 64'(instr_addr), 64'h5);
    chk("narrow_addr_end", 64'(instr_addr2), 64'h1);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
